// File: rtl/seq_det_pkg.sv
// Shared types and next-state function for the "three consecutive 1s" Moore detector.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package seq_det_pkg;

    // S0: no 1s seen, S1: one 1, S2: two 1s, S3: detection state (three 1s)
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } det_state_t;

    // One detector step. From S3 the incoming bit is consumed and the run
    // restarts from S0 unconditionally, so overlapping runs never chain.
    function automatic det_state_t det_next(input det_state_t state, input logic b);
        det_state_t nxt;
        case (state)
            S0:      nxt = b ? S1 : S0;
            S1:      nxt = b ? S2 : S0;
            S2:      nxt = b ? S3 : S0;
            S3:      nxt = S0;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
// Latency: combinational grant; pointer updates on the clock after a grant.
// Backpressure: a grant is a transfer; pointer holds while nothing is granted.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset (pointer -> N-1)
//   req          request vector (already qualified by any global enable)
//   advance      move the pointer to gnt_idx this cycle
//   gnt          one-hot grant, all zero when req is zero
//   gnt_idx      binary index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N-1:0]                        req,
    input  logic                                advance,
    output logic [N-1:0]                        gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;

    // Scan pointer+1 .. pointer+N (mod N); the first asserted request wins.
    always_comb begin
        logic          found;
        int            c;
        logic [IW-1:0] ci;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        c       = 0;
        ci      = '0;
        for (int k = 1; k <= N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            ci = IW'(c);
            if (!found && req[ci]) begin
                found   = 1'b1;
                gnt[ci] = 1'b1;
                gnt_idx = ci;
            end
        end
    end

    // Reset to N-1 so requester 0 has top priority after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= IW'(N - 1);
        end else if (advance) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Time-shared "three consecutive 1s" detector serving NUM_CH serial streams.
// Latency: det_valid/det_ch one clock after the handshake that reaches S3.
// Backpressure: req_ready is a combinational one-hot round-robin grant, zero when en=0.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   en           global enable; low blocks all grants and freezes states/pointer
//   req_valid    per-channel bit-present strobe
//   req_bit      per-channel serial bit
//   req_ready    one-hot grant; transfer on req_valid[i] & req_ready[i]
//   ch_clear     per-channel synchronous clear to S0 (wins over a same-cycle grant)
//   det_valid    one-cycle detection pulse
//   det_ch       channel of the latest detection, held between pulses
module seq_detect_sched
    import seq_det_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] req_valid,
    input  logic [NUM_CH-1:0] req_bit,
    output logic [NUM_CH-1:0] req_ready,
    input  logic [NUM_CH-1:0] ch_clear,
    output logic              det_valid,
    output logic [CH_W-1:0]   det_ch
);

    logic [NUM_CH-1:0] arb_req;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              xfer;

    det_state_t        st [NUM_CH];
    det_state_t        cur_st;
    det_state_t        nxt_st;
    logic              hit;

    // Gating the requests (not the grant) keeps the pointer frozen while en=0.
    assign arb_req = en ? req_valid : '0;
    assign xfer    = |gnt;

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (xfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;

    // Single shared next-state evaluation for whichever channel holds the grant.
    assign cur_st = st[gnt_idx];
    assign nxt_st = det_next(cur_st, req_bit[gnt_idx]);

    // A clear on the granted channel discards its bit, so it cannot detect.
    assign hit = xfer && !ch_clear[gnt_idx] && (nxt_st == S3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st[i] <= S0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clear[i]) begin
                    st[i] <= S0;
                end else if (gnt[i]) begin
                    st[i] <= nxt_st;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_valid <= 1'b0;
            det_ch    <= '0;
        end else begin
            det_valid <= hit;
            if (hit) begin
                det_ch <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked each cycle against a run-length model.
// Inputs change 2 time units after the rising edge; outputs are compared on the falling edge.
module tb_seq_detect_sched;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req_valid;
    logic [3:0] req_bit;
    logic [3:0] ch_clear;
    logic [3:0] req_ready;
    logic       det_valid;
    logic [1:0] det_ch;

    int tests;
    int fails;

    seq_detect_sched #(.NUM_CH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_bit   (req_bit),
        .req_ready (req_ready),
        .ch_clear  (ch_clear),
        .det_valid (det_valid),
        .det_ch    (det_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel is tracked as the length of its current run of accepted 1s
    // (0..3). Reaching 3 is a detection; the next accepted bit, whatever its
    // value, starts over from 0.
    int run [4];
    int mptr;
    bit mdet;
    int mch;

    always @(negedge clk) begin
        logic [3:0] eg;
        int         gi;
        bit         fnd;
        int         c;
        if (!rst) begin
            for (int i = 0; i < 4; i++) run[i] = 0;
            mptr = 3;
            mdet = 0;
            mch  = 0;
        end
        eg  = 4'b0;
        gi  = 0;
        fnd = 0;
        if (en) begin
            for (int k = 1; k <= 4; k++) begin
                c = (mptr + k) % 4;
                if (!fnd && req_valid[c]) begin
                    fnd   = 1;
                    gi    = c;
                    eg[c] = 1'b1;
                end
            end
        end
        chk("cmp_ready", req_ready, eg);
        chk("cmp_det_valid", det_valid, mdet);
        chk("cmp_det_ch", det_ch, mch);
        if (rst) begin
            mdet = 0;
            for (int i = 0; i < 4; i++) if (ch_clear[i]) run[i] = 0;
            if (fnd) begin
                mptr = gi;
                if (!ch_clear[gi]) begin
                    if (run[gi] == 3)      run[gi] = 0;
                    else if (req_bit[gi])  run[gi] = run[gi] + 1;
                    else                   run[gi] = 0;
                    if (run[gi] == 3) begin
                        mdet = 1;
                        mch  = gi;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // All helpers start and end 2 time units after a rising edge.
    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        req_bit   = '0;
        ch_clear  = '0;
        en        = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
    endtask

    // One cycle: drive, check the grant, clock, then check the detection outputs.
    task automatic send(input string nm, input logic [3:0] v, input logic [3:0] b,
                        input logic [3:0] clr, input logic [3:0] er,
                        input logic ed, input int ec);
        req_valid = v;
        req_bit   = b;
        ch_clear  = clr;
        #1;
        chk({nm, "_ready"}, req_ready, er);
        @(posedge clk);
        #2;
        chk({nm, "_det"}, det_valid, ed);
        if (ec >= 0) chk({nm, "_ch"}, det_ch, ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        req_bit   = '0;
        ch_clear  = '0;
        #2;
        do_reset();

        // Reset state
        chk("rst_det_valid", det_valid, 0);
        chk("rst_det_ch", det_ch, 0);
        chk("rst_ready", req_ready, 0);

        // 1: ch0 sends 1,1,1 then one more 1
        send("t1_b1", 4'b0001, 4'b0001, 4'b0, 4'b0001, 0, -1);
        send("t1_b2", 4'b0001, 4'b0001, 4'b0, 4'b0001, 0, -1);
        send("t1_b3", 4'b0001, 4'b0001, 4'b0, 4'b0001, 1, 0);
        send("t1_b4", 4'b0001, 4'b0001, 4'b0, 4'b0001, 0, -1);

        // 2: all four channels, bit=1, 12 cycles
        do_reset();
        for (int k = 0; k < 12; k++) begin
            send("t2", 4'b1111, 4'b1111, 4'b0, 4'(1 << (k % 4)),
                 (k >= 8), (k >= 8) ? (k - 8) : -1);
        end

        // 3: ch2 sends 1,1,0,1,1,1
        do_reset();
        send("t3_b1", 4'b0100, 4'b0100, 4'b0, 4'b0100, 0, -1);
        send("t3_b2", 4'b0100, 4'b0100, 4'b0, 4'b0100, 0, -1);
        send("t3_b3", 4'b0100, 4'b0000, 4'b0, 4'b0100, 0, -1);
        send("t3_b4", 4'b0100, 4'b0100, 4'b0, 4'b0100, 0, -1);
        send("t3_b5", 4'b0100, 4'b0100, 4'b0, 4'b0100, 0, -1);
        send("t3_b6", 4'b0100, 4'b0100, 4'b0, 4'b0100, 1, 2);

        // 4: ch1 in S2, clear together with a granted 1
        do_reset();
        send("t4_b1", 4'b0010, 4'b0010, 4'b0,    4'b0010, 0, -1);
        send("t4_b2", 4'b0010, 4'b0010, 4'b0,    4'b0010, 0, -1);
        send("t4_clr", 4'b0010, 4'b0010, 4'b0010, 4'b0010, 0, -1);
        send("t4_b3", 4'b0010, 4'b0010, 4'b0,    4'b0010, 0, -1);
        send("t4_b4", 4'b0010, 4'b0010, 4'b0,    4'b0010, 0, -1);
        send("t4_b5", 4'b0010, 4'b0010, 4'b0,    4'b0010, 1, 1);

        // 5: ch3 sends 1,1; en low 5 cycles; resume with 1
        do_reset();
        send("t5_b1", 4'b1000, 4'b1000, 4'b0, 4'b1000, 0, -1);
        send("t5_b2", 4'b1000, 4'b1000, 4'b0, 4'b1000, 0, -1);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send("t5_off", 4'b1000, 4'b1000, 4'b0, 4'b0000, 0, -1);
        end
        en = 1'b1;
        send("t5_b3", 4'b1000, 4'b1000, 4'b0, 4'b1000, 1, 3);

        // 6: reset mid-run with ch0 in S2, then async drop of a live pulse
        do_reset();
        send("t6_b1", 4'b0001, 4'b0001, 4'b0, 4'b0001, 0, -1);
        send("t6_b2", 4'b0001, 4'b0001, 4'b0, 4'b0001, 0, -1);
        rst = 1'b0;
        #1;
        chk("t6_rst_det", det_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        send("t6_b3", 4'b0001, 4'b0001, 4'b0, 4'b0001, 0, -1);
        send("t6_b4", 4'b0001, 4'b0001, 4'b0, 4'b0001, 0, -1);
        send("t6_b5", 4'b0001, 4'b0001, 4'b0, 4'b0001, 1, 0);
        rst = 1'b0;
        #1;
        chk("t6_async_det", det_valid, 0);
        chk("t6_async_ch", det_ch, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;

        // Randomized traffic, checked by the model on every cycle
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                en        = ($urandom_range(0, 9) != 0);
                req_valid = 4'($urandom);
                req_bit   = 4'($urandom | $urandom);
                ch_clear  = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
                @(posedge clk);
                #2;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
